// File: rtl/wheel_quadrature_tx.sv
// wheel_quadrature_tx
//
// Quadrature pulse generator for the wheel encoder link. A command emits a
// programmed number of Gray-coded steps on quad_a/quad_b. The steps go in the
// requested direction, one step every `period` clocks. The block also keeps a
// running signed position that tracks what the wheel counting datapath will
// accumulate.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   command strobe, sampled only in IDLE
//   dir       in   0 = CW, 1 = CCW (captured with start)
//   steps     in   STEP_W step count (captured with start)
//   period    in   DIV_W clocks per step, 0 treated as 1 (captured with start)
//   abort     in   terminates a running command (no step on that edge)
//   busy      out  command in progress (RUN)
//   done      out  one-cycle completion/abort pulse (FINISH)
//   quad_a/b  out  registered quadrature outputs
//   position  out  running step count, modulo 2^STEP_W
module wheel_quadrature_tx #(
    parameter int STEP_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dir,
    input  logic [STEP_W-1:0] steps,
    input  logic [DIV_W-1:0]  period,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              quad_a,
    output logic              quad_b,
    output logic [STEP_W-1:0] position
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    timer_q, timer_d;
    logic [DIV_W-1:0]    reload_q, reload_d;   // effective period minus one
    logic [STEP_W-1:0]   remain_q, remain_d;
    logic                dir_q, dir_d;
    logic [1:0]          ab_q, ab_d;           // {quad_a, quad_b}
    logic [STEP_W-1:0]   pos_q, pos_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DIV_W-1:0]    reload_in;
    logic [1:0]          ab_step;

    // A period of 0 behaves like 1, so both map to a reload value of 0.
    assign reload_in = (period == '0) ? '0 : (period - DIV_W'(1));

    // Gray sequence 00 -> 10 -> 11 -> 01 -> 00 is walked directly on the
    // output bits. Forward is {~b, a} and backward is {b, ~a}. Each move
    // flips exactly one bit, and the outputs come straight from flops.
    assign ab_step = dir_q ? {ab_q[0], ~ab_q[1]} : {~ab_q[0], ab_q[1]};

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        reload_d = reload_q;
        remain_d = remain_q;
        dir_d    = dir_q;
        ab_d     = ab_q;
        pos_d    = pos_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dir_d    = dir;
                    reload_d = reload_in;
                    timer_d  = reload_in;
                    remain_d = steps;
                    state_d  = (steps == '0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Any step due on this edge is dropped.
                    state_d = S_FINISH;
                end else if (timer_q == '0) begin
                    ab_d     = ab_step;
                    pos_d    = dir_q ? (pos_q - STEP_W'(1)) : (pos_q + STEP_W'(1));
                    remain_d = remain_q - STEP_W'(1);
                    timer_d  = reload_q;
                    if (remain_q == STEP_W'(1)) begin
                        state_d = S_FINISH;
                    end
                end else begin
                    timer_d = timer_q - DIV_W'(1);
                end
            end
            S_FINISH: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            reload_q <= '0;
            remain_q <= '0;
            dir_q    <= 1'b0;
            ab_q     <= 2'b00;
            pos_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            reload_q <= reload_d;
            remain_q <= remain_d;
            dir_q    <= dir_d;
            ab_q     <= ab_d;
            pos_q    <= pos_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quad_a   = ab_q[1];
    assign quad_b   = ab_q[0];
    assign position = pos_q;

endmodule

// File: tb/tb_wheel_quadrature_tx.sv
// Bench for wheel_quadrature_tx. Commands come from a table. Each expected
// phase/position change is pushed to a queue together with its due cycle.
// A negedge monitor pops an entry on every output change and compares it.
module tb_wheel_quadrature_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        dir_i = 1'b0;
    logic [7:0]  steps_i = '0;
    logic [15:0] period_i = '0;
    logic        abort = 1'b0;
    logic        busy, done, quad_a, quad_b;
    logic [7:0]  position;

    wheel_quadrature_tx #(.STEP_W(8), .DIV_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir_i), .steps(steps_i),
        .period(period_i), .abort(abort), .busy(busy), .done(done),
        .quad_a(quad_a), .quad_b(quad_b), .position(position)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int steps_seen = 0;
    logic mon_en = 1'b0;
    logic [9:0] prev_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] ab;
        logic [7:0] pos;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    // Bench-side model: phase index into the Gray table, and position.
    logic [1:0] ph_m = 2'd0;
    logic [7:0] pos_m = 8'd0;

    function automatic logic [1:0] gray(input logic [1:0] p);
        case (p)
            2'd0: return 2'b00;
            2'd1: return 2'b10;
            2'd2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Output-change monitor: every change must match the next queued step.
    always @(negedge clk) begin
        logic [9:0] cur;
        exp_t e;
        cur = {quad_a, quad_b, position};
        if (mon_en && cur !== prev_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output_change", int'(cur), int'(prev_out));
            end else begin
                e = exp_q.pop_front();
                check("step_ab", int'({quad_a, quad_b}), int'(e.ab));
                check("step_pos", int'(position), int'(e.pos));
                check("step_cycle", cyc, e.cyc);
                $display("[TB] step %0d: AB=%b%b pos=%0d cycle=%0d", steps_seen + 1,
                         quad_a, quad_b, position, cyc);
            end
            steps_seen++;
        end
        prev_out = cur;
    end

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_outputs", int'({quad_a, quad_b, position, busy, done}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ph_m = 2'd0;
        pos_m = 8'd0;
        exp_q.delete();
        prev_out = '0;
        mon_en = 1'b1;
    endtask

    task automatic run_cmd(input string name, input logic d, input logic [7:0] n,
                           input logic [15:0] per, input int abort_after, input bit ign,
                           input logic [7:0] exp_pos, input int exp_busy);
        int k, p, nexp, busy_cnt, done_cnt, done_cyc;
        bit abort_sent;
        exp_t e;
        p = (per == 0) ? 1 : int'(per);
        nexp = (abort_after >= 0) ? abort_after : int'(n);
        steps_seen = 0;
        @(negedge clk);
        start = 1'b1; dir_i = d; steps_i = n; period_i = per;
        @(posedge clk);
        #1;
        k = cyc;
        // Scramble the inputs so that any late sampling shows up.
        start = 1'b0; dir_i = ~d; steps_i = 8'hAA; period_i = 16'd3;
        for (int i = 1; i <= nexp; i++) begin
            ph_m  = d ? ph_m - 2'd1 : ph_m + 2'd1;
            pos_m = d ? pos_m - 8'd1 : pos_m + 8'd1;
            e.ab = gray(ph_m); e.pos = pos_m; e.cyc = k + i * p;
            exp_q.push_back(e);
        end
        busy_cnt = 0; done_cnt = 0; done_cyc = -1; abort_sent = 0;
        for (int b = 0; b < 3000 && done_cnt == 0; b++) begin
            @(negedge clk);
            #1;
            if (abort_after >= 0 && !abort_sent && steps_seen == abort_after) begin
                abort = 1'b1; abort_sent = 1;
            end else begin
                abort = 1'b0;
            end
            if (ign && busy_cnt == 3) begin
                start = 1'b1; dir_i = ~d; steps_i = 8'd50; period_i = 16'd1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
        end
        abort = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (done) done_cnt++;
        end
        // Stay idle for a while; any late or extra step is flagged by the monitor.
        repeat (20) @(negedge clk);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_busy_cycles"}, busy_cnt, exp_busy);
        if (n == 0)
            check({name, "_done_cycle_near_accept"}, int'(done_cyc == k || done_cyc == k + 1), 1);
        else if (abort_after < 0)
            check({name, "_done_cycle"}, done_cyc, k + int'(n) * p);
        check({name, "_position"}, int'(position), int'(exp_pos));
        check({name, "_pending_steps"}, exp_q.size(), 0);
        $display("[TB] cmd %s: dir=%0d steps=%0d period=%0d pos=%0d busy_cycles=%0d",
                 name, d, n, per, position, busy_cnt);
    endtask

    typedef struct {
        string       name;
        bit          rst;
        logic        d;
        logic [7:0]  n;
        logic [15:0] per;
        int          abort_after;
        bit          ign;
        logic [7:0]  exp_pos;
        int          exp_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int bad;
        vecs[0] = '{"cw5",       1'b1, 1'b0, 8'd5,  16'd4, -1, 1'b0, 8'd5,   20};
        vecs[1] = '{"ccw_wrap",  1'b1, 1'b1, 8'd3,  16'd0, -1, 1'b0, 8'd253, 3};
        vecs[2] = '{"zero",      1'b0, 1'b0, 8'd0,  16'd7, -1, 1'b0, 8'd253, 0};
        vecs[3] = '{"cw_wrap",   1'b0, 1'b0, 8'd3,  16'd1, -1, 1'b0, 8'd0,   3};
        vecs[4] = '{"ign_start", 1'b0, 1'b1, 8'd4,  16'd3, -1, 1'b1, 8'd252, 12};
        vecs[5] = '{"abort",     1'b1, 1'b0, 8'd10, 16'd8, 3,  1'b0, 8'd3,   25};

        // Reset, then 100 idle cycles with every output at 0.
        do_reset();
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            #1;
            if ({quad_a, quad_b, position, busy, done} !== '0) bad++;
        end
        check("idle_100_cycles_nonzero", bad, 0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            run_cmd(vecs[i].name, vecs[i].d, vecs[i].n, vecs[i].per,
                    vecs[i].abort_after, vecs[i].ign, vecs[i].exp_pos, vecs[i].exp_busy);
        end

        // Async reset in the middle of a run, applied between clock edges.
        mon_en = 1'b0;
        @(negedge clk);
        start = 1'b1; dir_i = 1'b0; steps_i = 8'd10; period_i = 16'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("busy_before_async_reset", int'(busy), 1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", int'({quad_a, quad_b, position, busy, done}), 0);
        @(negedge clk);
        reset = 1'b1;
        ph_m = 2'd0; pos_m = 8'd0; exp_q.delete(); prev_out = '0;
        mon_en = 1'b1;
        run_cmd("after_reset", 1'b0, 8'd2, 16'd2, -1, 1'b0, 8'd2, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
